// File: rtl/spi_cfg_regs.sv
// SPI configuration slave: auto-incrementing byte writes into a shadow register file,
// committed atomically to cfg at end of frame. Optional readback: define SPI_CFG_READBACK_EN.
module spi_cfg_regs #(
    parameter int NUM_REGS = 12,
    parameter int ADDR_W   = 4,
    parameter int SYNC_FF  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  nss,
    output logic                  miso,
    output logic [NUM_REGS*8-1:0] cfg,
    output logic                  cfg_valid,
    output logic                  trig,
    output logic                  mute,
    output logic                  frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   REGS_LIM  = (ADDR_W + 1)'(NUM_REGS);

    state_t               state_q, state_d;
    logic [SYNC_FF-1:0]   sclk_sync_q, mosi_sync_q, nss_sync_q;
    logic                 sclk_prev_q;
    logic                 armed_q, armed_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [6:0]           shift_q, shift_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 trig_req_q, trig_req_d;
    logic                 rd_q, rd_d;
    logic                 range_bad_q, range_bad_d;
    logic                 err_frame_q, err_frame_d;
    logic [7:0]           shadow_q [NUM_REGS];
    logic [7:0]           shadow_d [NUM_REGS];
    logic [7:0]           cfg_q    [NUM_REGS];
    logic [7:0]           cfg_d    [NUM_REGS];
    logic                 cfg_valid_q, cfg_valid_d;
    logic                 trig_q, trig_d;
    logic                 mute_q, mute_d;
    logic                 frame_err_q, frame_err_d;

    logic                 sclk_s, mosi_s, nss_s;
    logic                 sclk_rise, sclk_fall;
    logic [7:0]           byte_in;
    logic                 byte_done;
    logic [ADDR_W-1:0]    cmd_addr;

    assign sclk_s    = sclk_sync_q[SYNC_FF-1];
    assign mosi_s    = mosi_sync_q[SYNC_FF-1];
    assign nss_s     = nss_sync_q[SYNC_FF-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign byte_in   = {shift_q, mosi_s};
    assign cmd_addr  = byte_in[ADDR_W-1:0];
    assign byte_done = sclk_rise && !nss_s && (bit_cnt_q == 3'd7)
                       && ((state_q == CMD) || (state_q == DATA));

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // nss sync chain resets low so a frame already in progress at reset release
    // never looks like a fresh nss fall; armed_q waits for nss to be seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            nss_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            trig_req_q  <= 1'b0;
            rd_q        <= 1'b0;
            range_bad_q <= 1'b0;
            err_frame_q <= 1'b0;
            shadow_q    <= '{default: '0};
            cfg_q       <= '{default: '0};
            cfg_valid_q <= 1'b0;
            trig_q      <= 1'b0;
            mute_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_FF-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], mosi};
            nss_sync_q  <= {nss_sync_q[SYNC_FF-2:0], nss};
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            trig_req_q  <= trig_req_d;
            rd_q        <= rd_d;
            range_bad_q <= range_bad_d;
            err_frame_q <= err_frame_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            trig_q      <= trig_d;
            mute_q      <= mute_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | nss_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        trig_req_d  = trig_req_q;
        rd_d        = rd_q;
        range_bad_d = range_bad_q;
        err_frame_d = err_frame_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        trig_d      = 1'b0;
        mute_d      = ~nss_s & armed_q;
        frame_err_d = frame_err_q;

        if (nss_s || (state_q == IDLE) || (state_q == COMMIT)) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = byte_in[6:0];
        end

        case (state_q)
            IDLE: begin
                if (armed_q && !nss_s) begin
                    state_d     = CMD;
                    err_frame_d = 1'b0;
                    range_bad_d = 1'b0;
                    trig_req_d  = 1'b0;
                    rd_d        = 1'b0;
                end
            end
            CMD: begin
                if (nss_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (byte_done) begin
                    state_d    = DATA;
                    trig_req_d = byte_in[7];
`ifdef SPI_CFG_READBACK_EN
                    rd_d       = byte_in[6];
`else
                    rd_d       = 1'b0;
`endif
                    addr_d     = cmd_addr;
                    if ({1'b0, cmd_addr} >= REGS_LIM) begin
                        range_bad_d = 1'b1;
                        err_frame_d = 1'b1;
                    end
                end
            end
            DATA: begin
                // Commit on nss rise; any partial trailing byte is dropped but flagged.
                if (nss_s) begin
                    state_d     = COMMIT;
                    cfg_d       = shadow_q;
                    cfg_valid_d = 1'b1;
                    trig_d      = trig_req_q;
                    frame_err_d = err_frame_q | (bit_cnt_q != 3'd0);
                end else if (byte_done) begin
                    if (!rd_q && !range_bad_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == ADDR_W'(i)) shadow_d[i] = byte_in;
                        end
                    end
                    addr_d = next_addr(addr_q);
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_CFG_READBACK_EN
    logic       miso_q, miso_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rb_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
            tx_q   <= '0;
        end else begin
            miso_q <= miso_d;
            tx_q   <= tx_d;
        end
    end

    // A fall with bit count 0 starts a new byte: load the live register at addr.
    always_comb begin
        rb_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) rb_byte = cfg_q[i];
        end
        miso_d = 1'b0;
        tx_d   = tx_q;
        if ((state_q == DATA) && rd_q && !nss_s) begin
            miso_d = miso_q;
            if (sclk_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    miso_d = rb_byte[7];
                    tx_d   = {rb_byte[6:0], 1'b0};
                end else begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    assign miso = miso_q;
`else
    assign miso = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg[8*g +: 8] = cfg_q[g];
    end

    assign cfg_valid = cfg_valid_q;
    assign trig      = trig_q;
    assign mute      = mute_q;
    assign frame_err = frame_err_q;

endmodule
